// File: rtl/cla_seq_adder_ctrl_pkg.sv
// Shared constants for the nibble-serial adder sequencer: FSM encoding and slice width.
package cla_seq_adder_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_seq_adder_ctrl_cla.sv
// 4-bit carry-lookahead adder slice, shared across all nibble passes.
module cla_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       carry
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Flat lookahead terms so no carry ripples through the slice.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum   = p ^ c[3:0];
  assign carry = c[4];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Sequencer that time-multiplexes one 4-bit CLA slice to add/subtract WIDTH-bit
// operands, LSB nibble first, with the carry held between passes.
//
// state   | meaning
// IDLE    | waiting for an operation, in_ready=1
// RUN     | one nibble per clock through the shared slice
// DONE    | result held until out_ready
module cla_seq_adder_ctrl
  import cla_seq_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = $clog2(NSLICE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   sum_sr;
  logic               carry;
  logic               a_msb;
  logic               b_msb;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_carry;
  logic               accept;

  cla_adder u_slice (
    .a     (a_sr[SLICE_W-1:0]),
    .b     (b_sr[SLICE_W-1:0]),
    .cin   (carry),
    .sum   (slice_sum),
    .carry (slice_carry)
  );

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN:  if (cnt == CNT_LAST) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (accept) begin
        // Subtraction folds into addition: a + ~b + 1.
        a_sr  <= a;
        b_sr  <= sub ? ~b : b;
        carry <= sub ? 1'b1 : cin;
        a_msb <= a[WIDTH-1];
        b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
        cnt   <= '0;
      end
    end else if (state == ST_RUN) begin
      a_sr   <= a_sr >> SLICE_W;
      b_sr   <= b_sr >> SLICE_W;
      sum_sr <= {slice_sum, sum_sr[WIDTH-1:SLICE_W]};
      carry  <= slice_carry;
      cnt    <= cnt + 1'b1;
    end
  end

  assign sum  = sum_sr;
  assign cout = carry;
  assign ovf  = (a_msb == b_msb) && (sum_sr[WIDTH-1] != a_msb);

endmodule
